mic1_run_ctrl: RTL and testbench
================================

// Module: mic1_run_ctrl
// PURPOSE
// Run/step sequencer for the MIC-1 datapath. It sits between the debounced front-panel buttons
// (Button_Debouncer outputs) and the MIC-1 core. It issues clock-enable pulses to the core in
// free-run or single-step mode, holds the core in synchronous reset on CLEAR, halts on a
// microprogram breakpoint, and counts executed micro-cycles for the LEDs.
// PARAMETERS
// RATE_DIV    4   RUN mode: one mic1_ce pulse every RATE_DIV clk cycles (>=1; 1 = continuous)
// CNT_W       16  width of the executed-micro-cycle counter
// MPC_W       9   width of MIC-1 MPC / breakpoint address
// RST_CYCLES  4   number of clk cycles mic1_srst is held in CLEAR (>=1)
// PORTS
// clk        in   1      system clock
// resetn     in   1      asynchronous active-low reset
// btn_run    in   1      debounced level, Up button
// btn_step   in   1      debounced level, Right button
// btn_stop   in   1      debounced level, Down button
// btn_clr    in   1      debounced level, Center button
// bp_en      in   1      breakpoint enable
// bp_addr    in   MPC_W  breakpoint MPC address
// mpc        in   MPC_W  current MIC-1 MPC (valid the cycle after a ce pulse)
// mic1_halt  in   1      core self-halt request (level)
// mic1_ce    out  1      core clock enable, registered, one-cycle pulses
// mic1_srst  out  1      core synchronous reset, registered
// led_run    out  1      high in RUN or STEP
// led_idle   out  1      high in IDLE or HALT
// led_step   out  4      cycle_cnt[3:0]
// cycle_cnt  out  CNT_W  executed ce pulses since last CLEAR
// state_o    out  3      ctrl_state_t encoding, for debug
// BEHAVIOUR
// - Reset (resetn=0, async): state=CLEAR, mic1_ce=0, mic1_srst=1, cycle_cnt=0, prescaler=0,
//   led_run=0, led_idle=0, edge-detector history=1 (a button held through reset gives no edge).
// - Button commands are single-cycle rising edges of btn_*. Priority: clr > stop > run > step.
// - CLEAR: mic1_srst=1 for RST_CYCLES clk cycles, cycle_cnt=0, then IDLE. clr edge re-enters
//   CLEAR and restarts the hold count.
// - IDLE: run edge -> RUN (prescaler=0); step edge -> STEP.
// - RUN: prescaler counts 0..RATE_DIV-1. mic1_ce=1 for one cycle when it wraps, so the first
//   pulse occurs RATE_DIV cycles after entry.
//   stop edge -> IDLE. mic1_halt=1 -> HALT.
//   Breakpoint: if bp_en && mpc==bp_addr in the cycle after a ce pulse -> HALT.
//   Check masked for the first pulse after entering RUN from HALT, so the core can leave bp_addr.
// - STEP: exactly one mic1_ce pulse, in the cycle after entry, then IDLE. Breakpoint ignored.
// - HALT: mic1_ce=0. run edge -> RUN (breakpoint mask set); step edge -> STEP;
//   stop edge -> IDLE; clr edge -> CLEAR.
// - Simultaneous events: stop/clr in the same cycle as a due ce pulse suppresses the pulse.
//   mic1_halt and a breakpoint together -> HALT (single transition).
// - cycle_cnt increments on every issued ce pulse and wraps 2^CNT_W-1 -> 0. No other arithmetic.
// - Latency: command edge to state change is 1 clk. mic1_ce is registered, so the pulse trails
//   its decision by 1 clk.
// - Async reset mid-RUN: ce drops immediately, core held in srst, sequence restarts at CLEAR.
// STRUCTURE
// - Package mic1_ctrl_pkg holds:
//   typedef enum logic[2:0] ctrl_state_t {CLEAR=0, IDLE=1, RUN=2, STEP=3, HALT=4};
//   localparam button index constants.
// - Sub-module btn_edge (param W=4): registered rising-edge detector, async reset of history to 1.
// - Remainder in one module: FSM, prescaler, reset-hold counter, cycle counter.
// TESTING
// 1 Reset release, no buttons -> srst high 4 clk, then state IDLE, ce never asserted, cnt=0.
// 2 IDLE, btn_step pulse x3 -> exactly 3 single ce pulses, cycle_cnt=3, led_step=4'h3,
//   back in IDLE each time.
// 3 btn_run, RATE_DIV=4, 40 clk -> ce every 4th clk (10 pulses). btn_stop -> IDLE,
//   no further ce.
// 4 bp_en=1, bp_addr=9'h00A, mpc model hits 0x00A on 3rd pulse -> HALT, cnt=3. btn_run ->
//   resumes, no immediate re-halt.
// 5 btn_stop and due ce pulse in the same clk -> no ce, IDLE. btn_clr+btn_run together -> CLEAR.
// 6 resetn low mid-RUN -> ce=0 and srst=1 async. Button held across reset -> no edge. cnt wrap
//   at CNT_W=4: 16 pulses -> 0.

Source files
------------

// File: rtl/mic1_ctrl_pkg.sv
// Shared state encoding and button lane indices for the MIC-1 run/step sequencer.
package mic1_ctrl_pkg;

    typedef enum logic [2:0] {
        CLEAR = 3'd0,
        IDLE  = 3'd1,
        RUN   = 3'd2,
        STEP  = 3'd3,
        HALT  = 3'd4
    } ctrl_state_t;

    localparam int BTN_RUN  = 0;
    localparam int BTN_STEP = 1;
    localparam int BTN_STOP = 2;
    localparam int BTN_CLR  = 3;
    localparam int BTN_NUM  = 4;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for debounced button levels; edge is valid in the cycle the level rises.
// History resets to 1 so a button held through reset never produces a spurious command.
module btn_edge #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] btn_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] hist_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist_q <= '1;
        end else begin
            hist_q <= btn_i;
        end
    end

    assign rise_o = btn_i & ~hist_q;

endmodule

// File: rtl/mic1_run_ctrl.sv
// Run/step sequencer for the MIC-1 core: ce pulses, CLEAR reset hold, breakpoint halt, cycle count.
// Commands act 1 clk after the button edge; mic1_ce/mic1_srst are registered one clk after decision.
module mic1_run_ctrl
    import mic1_ctrl_pkg::*;
#(
    parameter int RATE_DIV   = 4,
    parameter int CNT_W      = 16,
    parameter int MPC_W      = 9,
    parameter int RST_CYCLES = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             btn_stop,
    input  logic             btn_clr,
    input  logic             bp_en,
    input  logic [MPC_W-1:0] bp_addr,
    input  logic [MPC_W-1:0] mpc,
    input  logic             mic1_halt,
    output logic             mic1_ce,
    output logic             mic1_srst,
    output logic             led_run,
    output logic             led_idle,
    output logic [3:0]       led_step,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [2:0]       state_o
);

    localparam int PW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(RATE_DIV - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

    logic [BTN_NUM-1:0] rise;
    logic cmd_clr, cmd_stop, cmd_run, cmd_step, bp_hit;

    ctrl_state_t      state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ce_q, ce_d, ce_dly_q, srst_q, mask_q, mask_d;

    btn_edge #(.W(BTN_NUM)) u_btn_edge (
        .clk    (clk),
        .resetn (resetn),
        .btn_i  ({btn_clr, btn_stop, btn_step, btn_run}),
        .rise_o (rise)
    );

    // Resolve simultaneous edges to a single command: clr > stop > run > step.
    assign cmd_clr  = rise[BTN_CLR];
    assign cmd_stop = rise[BTN_STOP] & ~cmd_clr;
    assign cmd_run  = rise[BTN_RUN]  & ~cmd_clr & ~rise[BTN_STOP];
    assign cmd_step = rise[BTN_STEP] & ~cmd_clr & ~rise[BTN_STOP] & ~rise[BTN_RUN];

    // MPC reflects the last pulse one cycle after ce, hence the delayed-ce qualifier.
    assign bp_hit = bp_en && (mpc == bp_addr) && ce_dly_q && !mask_q;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        rcnt_d  = rcnt_q;
        mask_d  = mask_q;
        ce_d    = 1'b0;
        if (cmd_clr) begin
            state_d = CLEAR;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (rcnt_q == RST_LAST) begin
                        state_d = IDLE;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (cmd_run) begin
                        state_d = RUN;
                        presc_d = '0;
                        mask_d  = 1'b0;
                    end else if (cmd_step) begin
                        state_d = STEP;
                    end
                end
                RUN: begin
                    if (ce_dly_q) begin
                        mask_d = 1'b0;
                    end
                    if (cmd_stop) begin
                        state_d = IDLE;
                    end else if (mic1_halt || bp_hit) begin
                        state_d = HALT;
                    end else if (presc_q == PRE_LAST) begin
                        presc_d = '0;
                        ce_d    = 1'b1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                STEP: begin
                    state_d = IDLE;
                    ce_d    = !cmd_stop;
                end
                HALT: begin
                    if (cmd_stop) begin
                        state_d = IDLE;
                    end else if (cmd_run) begin
                        state_d = RUN;
                        presc_d = '0;
                        mask_d  = 1'b1;
                    end else if (cmd_step) begin
                        state_d = STEP;
                    end
                end
                default: state_d = CLEAR;
            endcase
        end
        cnt_d = (state_d == CLEAR) ? '0 : cnt_q + CNT_W'(ce_d);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= CLEAR;
            presc_q  <= '0;
            rcnt_q   <= '0;
            cnt_q    <= '0;
            ce_q     <= 1'b0;
            ce_dly_q <= 1'b0;
            srst_q   <= 1'b1;
            mask_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            rcnt_q   <= rcnt_d;
            cnt_q    <= cnt_d;
            ce_q     <= ce_d;
            ce_dly_q <= ce_q;
            srst_q   <= (state_d == CLEAR);
            mask_q   <= mask_d;
        end
    end

    assign mic1_ce   = ce_q;
    assign mic1_srst = srst_q;
    assign led_run   = (state_q == RUN) || (state_q == STEP);
    assign led_idle  = (state_q == IDLE) || (state_q == HALT);
    assign led_step  = cnt_q[3:0];
    assign cycle_cnt = cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mic1_run_ctrl.sv
// Bench for mic1_run_ctrl: queue of expected ce cycles, a command-vector table, and hand sequences.
module tb_mic1_run_ctrl;
    import mic1_ctrl_pkg::*;

    localparam logic [3:0] M_NONE = 4'b0000;
    localparam logic [3:0] M_RUN  = 4'b0001;
    localparam logic [3:0] M_STEP = 4'b0010;
    localparam logic [3:0] M_STOP = 4'b0100;
    localparam logic [3:0] M_CLR  = 4'b1000;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [3:0] btn = 4'b0;
    logic       bp_en = 1'b0;
    logic [8:0] bp_addr = 9'h000;
    logic       mic1_halt = 1'b0;
    logic [8:0] mpc_base = 9'h000;
    logic [8:0] core_steps = 9'h000;
    logic [8:0] mpc;

    logic        ce16, srst16, lrun16, lidle16;
    logic [3:0]  lstep16;
    logic [15:0] cnt16;
    logic [2:0]  st16;
    logic        ce4, srst4, lrun4, lidle4;
    logic [3:0]  lstep4;
    logic [3:0]  cnt4;
    logic [2:0]  st4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_cnt = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    // Simple core model: MPC advances once per executed ce pulse.
    always @(posedge clk) begin
        if (ce16) core_steps <= core_steps + 9'd1;
    end
    assign mpc = mpc_base + core_steps;

    mic1_run_ctrl #(.RATE_DIV(4), .CNT_W(16), .MPC_W(9), .RST_CYCLES(4)) dut (
        .clk(clk), .resetn(resetn),
        .btn_run(btn[BTN_RUN]), .btn_step(btn[BTN_STEP]),
        .btn_stop(btn[BTN_STOP]), .btn_clr(btn[BTN_CLR]),
        .bp_en(bp_en), .bp_addr(bp_addr), .mpc(mpc), .mic1_halt(mic1_halt),
        .mic1_ce(ce16), .mic1_srst(srst16), .led_run(lrun16), .led_idle(lidle16),
        .led_step(lstep16), .cycle_cnt(cnt16), .state_o(st16)
    );

    mic1_run_ctrl #(.RATE_DIV(4), .CNT_W(4), .MPC_W(9), .RST_CYCLES(4)) dut_w4 (
        .clk(clk), .resetn(resetn),
        .btn_run(btn[BTN_RUN]), .btn_step(btn[BTN_STEP]),
        .btn_stop(btn[BTN_STOP]), .btn_clr(btn[BTN_CLR]),
        .bp_en(bp_en), .bp_addr(bp_addr), .mpc(mpc), .mic1_halt(mic1_halt),
        .mic1_ce(ce4), .mic1_srst(srst4), .led_run(lrun4), .led_idle(lidle4),
        .led_step(lstep4), .cycle_cnt(cnt4), .state_o(st4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock; ce is compared against the scoreboard on the falling edge.
    task automatic tick();
        logic due;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        due = (exp_q.size() != 0) && (exp_q[0] == cyc);
        chk("ce_pulse", 32'(ce16), 32'(due));
        if (due) void'(exp_q.pop_front());
        chk("narrow_cnt_mirror", 32'({ce4, srst4, lrun4, lidle4, lstep4, st4}),
            32'({ce16, srst16, lrun16, lidle16, lstep16, st16}));
    endtask

    task automatic press(input logic [3:0] m);
        btn = m;
        tick();
        btn = M_NONE;
    endtask

    task automatic chk_cnt(input string name);
        chk(name, 32'(cnt16), 32'(exp_cnt[15:0]));
        chk({name, "_w4"}, 32'(cnt4), 32'(exp_cnt[3:0]));
    endtask

    typedef struct {
        logic [3:0]  btn;
        ctrl_state_t st;
        int          ce_at;
    } vec_t;

    vec_t tv[17];

    initial begin
        int n;
        tv[0]  = '{M_STEP,          STEP,  2};
        tv[1]  = '{M_RUN | M_STEP,  RUN,   0};
        tv[2]  = '{M_RUN,           RUN,   0};
        tv[3]  = '{M_STOP | M_STEP, IDLE,  0};
        tv[4]  = '{M_STOP,          IDLE,  0};
        tv[5]  = '{M_RUN,           RUN,   0};
        tv[6]  = '{M_CLR | M_STOP,  CLEAR, 0};
        tv[7]  = '{M_RUN,           CLEAR, 0};
        tv[8]  = '{M_CLR,           CLEAR, 0};
        tv[9]  = '{M_NONE,          CLEAR, 0};
        tv[10] = '{M_NONE,          IDLE,  0};
        tv[11] = '{M_STEP,          STEP,  2};
        tv[12] = '{M_RUN,           RUN,   0};
        tv[13] = '{M_STEP,          RUN,   0};
        tv[14] = '{M_CLR,           CLEAR, 0};
        tv[15] = '{M_NONE,          CLEAR, 0};
        tv[16] = '{M_NONE,          IDLE,  0};

        // Reset values, then the CLEAR hold after release.
        #1 resetn = 1'b0;
        #1;
        chk("rst_ce", 32'(ce16), 32'(0));
        chk("rst_srst", 32'(srst16), 32'(1));
        chk("rst_state", 32'(st16), 32'(CLEAR));
        chk("rst_cnt", 32'(cnt16), 32'(0));
        chk("rst_leds", 32'({lrun16, lidle16, lstep16}), 32'(0));
        tick();
        tick();
        resetn = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("hold%0d_srst", k), 32'(srst16), 32'(1));
            chk($sformatf("hold%0d_state", k), 32'(st16), 32'(CLEAR));
        end
        tick();
        chk("release_srst", 32'(srst16), 32'(0));
        chk("release_state", 32'(st16), 32'(IDLE));
        chk("release_led_idle", 32'(lidle16), 32'(1));
        chk_cnt("release_cnt");

        // Three single steps.
        for (int k = 0; k < 3; k++) begin
            n = cyc;
            exp_q.push_back(n + 2);
            exp_cnt++;
            press(M_STEP);
            chk($sformatf("step%0d_state", k), 32'(st16), 32'(STEP));
            chk($sformatf("step%0d_led_run", k), 32'(lrun16), 32'(1));
            tick();
            chk($sformatf("step%0d_idle", k), 32'(st16), 32'(IDLE));
        end
        chk_cnt("step_cnt");
        chk("step_led_step", 32'(lstep16), 32'(4'h3));

        // Free run for 40 clocks, then stop.
        n = cyc;
        for (int k = 0; k < 10; k++) exp_q.push_back(n + 5 + 4 * k);
        exp_cnt += 10;
        press(M_RUN);
        chk("run_state", 32'(st16), 32'(RUN));
        while (cyc < n + 42) tick();
        press(M_STOP);
        chk("stop_state", 32'(st16), 32'(IDLE));
        repeat (12) tick();
        chk_cnt("run_cnt");

        // Breakpoint on the third pulse; also wraps the 4-bit counter to 0.
        bp_en = 1'b1;
        bp_addr = 9'h00A;
        mpc_base = 9'h007 - core_steps;
        n = cyc;
        for (int k = 0; k < 3; k++) exp_q.push_back(n + 5 + 4 * k);
        exp_cnt += 3;
        press(M_RUN);
        while (cyc < n + 14) tick();
        chk("bp_pre_state", 32'(st16), 32'(RUN));
        tick();
        chk("bp_halt_state", 32'(st16), 32'(HALT));
        repeat (6) tick();
        chk("bp_hold_state", 32'(st16), 32'(HALT));
        chk("bp_led_idle", 32'(lidle16), 32'(1));
        chk_cnt("bp_cnt");
        chk("wrap_cnt_w4", 32'(cnt4), 32'(0));

        // Resume: the core sits at bp_addr after the first pulse, which must not re-halt.
        mpc_base = mpc_base - 9'd1;
        n = cyc;
        for (int k = 0; k < 3; k++) exp_q.push_back(n + 5 + 4 * k);
        exp_cnt += 3;
        press(M_RUN);
        while (cyc < n + 14) tick();
        chk("resume_state", 32'(st16), 32'(RUN));
        press(M_STOP);
        chk("resume_stop", 32'(st16), 32'(IDLE));
        bp_en = 1'b0;

        // Core halt request, then a single step out of HALT.
        press(M_RUN);
        tick();
        mic1_halt = 1'b1;
        tick();
        chk("core_halt_state", 32'(st16), 32'(HALT));
        mic1_halt = 1'b0;
        repeat (3) tick();
        chk("core_halt_hold", 32'(st16), 32'(HALT));
        n = cyc;
        exp_q.push_back(n + 2);
        exp_cnt++;
        press(M_STEP);
        chk("halt_step_state", 32'(st16), 32'(STEP));
        tick();
        chk("halt_step_idle", 32'(st16), 32'(IDLE));
        chk_cnt("halt_step_cnt");

        // Command table: priorities, suppressed pulses, CLEAR restart.
        for (int i = 0; i < 17; i++) begin
            n = cyc;
            if (tv[i].ce_at != 0) begin
                exp_q.push_back(n + tv[i].ce_at);
                exp_cnt++;
            end
            if (tv[i].st == CLEAR) exp_cnt = 0;
            press(tv[i].btn);
            chk($sformatf("vec%0d_state", i), 32'(st16), 32'(tv[i].st));
            chk($sformatf("vec%0d_srst", i), 32'(srst16), 32'(tv[i].st == CLEAR));
            chk($sformatf("vec%0d_leds", i), 32'({lrun16, lidle16}),
                32'({(tv[i].st == RUN) || (tv[i].st == STEP),
                     (tv[i].st == IDLE) || (tv[i].st == HALT)}));
            tick();
            chk_cnt($sformatf("vec%0d_cnt", i));
        end

        // Async reset mid-RUN with the run button held across it.
        n = cyc;
        exp_q.push_back(n + 5);
        btn[BTN_RUN] = 1'b1;
        tick();
        chk("ar_run_state", 32'(st16), 32'(RUN));
        while (cyc < n + 5) tick();
        #2 resetn = 1'b0;
        #1;
        exp_cnt = 0;
        chk("ar_ce", 32'(ce16), 32'(0));
        chk("ar_srst", 32'(srst16), 32'(1));
        chk("ar_state", 32'(st16), 32'(CLEAR));
        chk_cnt("ar_cnt");
        tick();
        tick();
        resetn = 1'b1;
        repeat (4) tick();
        chk("ar_idle", 32'(st16), 32'(IDLE));
        repeat (4) tick();
        chk("ar_held_btn_no_edge", 32'(st16), 32'(IDLE));
        btn = M_NONE;
        tick();
        chk_cnt("ar_final_cnt");
        chk("ce_queue_drained", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
